// File: rtl/muntjac_pkg.sv
// Shared MMU types: page permissions and the TLB entry layout.
package muntjac_pkg;

  localparam int unsigned VirtAddrLen = 39;
  localparam int unsigned PhysAddrLen = 56;
  localparam int unsigned VpnLen      = VirtAddrLen - 12;
  localparam int unsigned PpnLen      = PhysAddrLen - 12;

  typedef struct packed {
    logic dirty;
    logic accessed;
    logic is_global;
    logic user;
    logic executable;
    logic writable;
    logic readable;
    logic valid;
  } page_prot_t;

  typedef struct packed {
    logic              valid;
    logic [VpnLen-1:0] vpn;
    logic [PpnLen-1:0] ppn;
    page_prot_t        perm;
  } tlb_entry_t;

endpackage

// File: rtl/muntjac_tlb_victim_sel.sv
// Refill victim choice: lowest invalid entry first, else a round-robin pointer.
module muntjac_tlb_victim_sel #(
  parameter int unsigned NumEntries = 8,
  localparam int unsigned IdxW = $clog2(NumEntries)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumEntries-1:0] valid_i,
  input  logic                  refill_i,
  output logic [IdxW-1:0]       victim_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            has_invalid;

  always_comb begin
    has_invalid = 1'b0;
    victim_o    = ptr_q;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        has_invalid = 1'b1;
        victim_o    = IdxW'(i);
      end
    end
  end

  // Pointer only moves when a valid entry is actually evicted.
  always_comb begin
    ptr_d = ptr_q;
    if (refill_i && !has_invalid) ptr_d = ptr_q + IdxW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/muntjac_tlb.sv
// Fully-associative TLB in front of the Sv39 walker; faults are never cached.
// MUNTJAC_TLB_KEEP_GLOBAL_EN: flush spares entries marked global.
module muntjac_tlb import muntjac_pkg::*; #(
  parameter int unsigned NumEntries = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [VpnLen-1:0] req_vpn_i,
  output logic              resp_valid_o,
  output logic [PpnLen-1:0] resp_ppn_o,
  output page_prot_t        resp_perm_o,
  output logic              ptw_req_valid_o,
  output logic [VpnLen-1:0] ptw_req_vpn_o,
  input  logic              ptw_resp_valid_i,
  input  logic [PpnLen-1:0] ptw_resp_ppn_i,
  input  page_prot_t        ptw_resp_perm_i
);

  localparam int unsigned IdxW = $clog2(NumEntries);

  typedef enum logic [1:0] {StIdle, StLookup, StWalk, StRespond} state_e;

  state_e            state_q, state_d;
  logic [VpnLen-1:0] vpn_q, vpn_d;
  logic [PpnLen-1:0] ppn_q, ppn_d;
  page_prot_t        perm_q, perm_d;
  logic              flushed_q, flushed_d;
  tlb_entry_t        entries_q [NumEntries];
  tlb_entry_t        entries_d [NumEntries];

  logic [NumEntries-1:0] valid_vec;
  logic [IdxW-1:0]       victim;
  logic                  refill;
  logic                  hit;
  logic [PpnLen-1:0]     hit_ppn;
  page_prot_t            hit_perm;

  always_comb begin
    hit      = 1'b0;
    hit_ppn  = '0;
    hit_perm = '0;
    for (int i = 0; i < NumEntries; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && entries_q[i].vpn == vpn_q) begin
        hit      = 1'b1;
        hit_ppn  = entries_q[i].ppn;
        hit_perm = entries_q[i].perm;
      end
    end
  end

  muntjac_tlb_victim_sel #(
    .NumEntries (NumEntries)
  ) u_victim_sel (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_vec),
    .refill_i (refill),
    .victim_o (victim)
  );

  assign ptw_req_vpn_o = vpn_q;

  always_comb begin
    state_d         = state_q;
    vpn_d           = vpn_q;
    ppn_d           = ppn_q;
    perm_d          = perm_q;
    flushed_d       = flushed_q;
    refill          = 1'b0;
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_ppn_o      = ppn_q;
    resp_perm_o     = perm_q;
    ptw_req_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = !flush_i;
        if (req_valid_i && !flush_i) begin
          vpn_d   = req_vpn_i;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit && !flush_i) begin
          resp_valid_o = 1'b1;
          resp_ppn_o   = hit_ppn;
          resp_perm_o  = hit_perm;
          req_ready_o  = 1'b1;
          if (req_valid_i) vpn_d = req_vpn_i;
          else             state_d = StIdle;
        end else begin
          ptw_req_valid_o = 1'b1;
          state_d         = StWalk;
          if (flush_i) flushed_d = 1'b1;
        end
      end
      StWalk: begin
        if (flush_i) flushed_d = 1'b1;
        if (ptw_resp_valid_i) begin
          ppn_d   = ptw_resp_ppn_i;
          perm_d  = ptw_resp_perm_i;
          // A flush in this very cycle also invalidates the walk result.
          refill  = ptw_resp_perm_i.valid && !flushed_q && !flush_i;
          state_d = StRespond;
        end
      end
      StRespond: begin
        resp_valid_o = 1'b1;
        flushed_d    = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  always_comb begin
    entries_d = entries_q;
    if (flush_i) begin
      for (int i = 0; i < NumEntries; i++) begin
`ifdef MUNTJAC_TLB_KEEP_GLOBAL_EN
        if (!entries_q[i].perm.is_global) entries_d[i].valid = 1'b0;
`else
        entries_d[i].valid = 1'b0;
`endif
      end
    end
    if (refill) begin
      entries_d[victim].valid = 1'b1;
      entries_d[victim].vpn   = vpn_q;
      entries_d[victim].ppn   = ptw_resp_ppn_i;
      entries_d[victim].perm  = ptw_resp_perm_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      vpn_q     <= '0;
      ppn_q     <= '0;
      perm_q    <= '0;
      flushed_q <= 1'b0;
      entries_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      vpn_q     <= vpn_d;
      ppn_q     <= ppn_d;
      perm_q    <= perm_d;
      flushed_q <= flushed_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_muntjac_tlb.sv
// Scoreboard bench for muntjac_tlb with a fixed-latency walker model.
module tb_muntjac_tlb;
  import muntjac_pkg::*;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [VpnLen-1:0] req_vpn_i = '0;
  logic              resp_valid_o;
  logic [PpnLen-1:0] resp_ppn_o;
  page_prot_t        resp_perm_o;
  logic              ptw_req_valid_o;
  logic [VpnLen-1:0] ptw_req_vpn_o;
  logic              ptw_resp_valid_i = 1'b0;
  logic [PpnLen-1:0] ptw_resp_ppn_i = '0;
  page_prot_t        ptw_resp_perm_i = '0;

  muntjac_tlb #(
    .NumEntries (8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_vpn_i        (req_vpn_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ppn_o       (resp_ppn_o),
    .resp_perm_o      (resp_perm_o),
    .ptw_req_valid_o  (ptw_req_valid_o),
    .ptw_req_vpn_o    (ptw_req_vpn_o),
    .ptw_resp_valid_i (ptw_resp_valid_i),
    .ptw_resp_ppn_i   (ptw_resp_ppn_i),
    .ptw_resp_perm_i  (ptw_resp_perm_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PpnLen-1:0] ppn;
    logic              v;
  } exp_t;

  exp_t              sb[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                ptw_cnt = 0;
  logic [VpnLen-1:0] last_vpn = '0;
`ifdef MUNTJAC_TLB_KEEP_GLOBAL_EN
  localparam int GlobalWalks = 0;
`else
  localparam int GlobalWalks = 1;
`endif

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [PpnLen-1:0] walk_ppn(input logic [VpnLen-1:0] vpn);
    if (vpn == 27'h0012345) return 44'hABCDE;
    return {17'h0, vpn ^ 27'h5A5A5};
  endfunction

  function automatic page_prot_t walk_perm(input logic [VpnLen-1:0] vpn);
    page_prot_t p;
    p           = '0;
    p.valid     = (vpn != 27'h7);
    p.readable  = 1'b1;
    p.writable  = 1'b1;
    p.accessed  = 1'b1;
    p.is_global = vpn[9];
    return p;
  endfunction

  // Walker model: answers three cycles after each request pulse.
  initial begin
    logic [VpnLen-1:0] v;
    forever begin
      @(negedge clk);
      if (rst_ni && ptw_req_valid_o) begin
        ptw_cnt++;
        v = ptw_req_vpn_o;
        check_eq("ptw_vpn", v, last_vpn);
        repeat (3) @(posedge clk);
        #1;
        ptw_resp_valid_i = 1'b1;
        ptw_resp_ppn_i   = walk_ppn(v);
        ptw_resp_perm_i  = walk_perm(v);
        @(posedge clk);
        #1;
        ptw_resp_valid_i = 1'b0;
      end
    end
  end

  // Response scoreboard and protocol monitor.
  initial begin
    exp_t e;
    logic ptw_prev;
    ptw_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (resp_valid_o) begin
          check_eq("sb_pending", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("resp_perm_v", resp_perm_o.valid, e.v);
            if (e.v) check_eq("resp_ppn", resp_ppn_o, e.ppn);
          end
        end
        if (req_valid_i && req_ready_o) begin
          e.ppn = walk_ppn(req_vpn_i);
          e.v   = walk_perm(req_vpn_i).valid;
          sb.push_back(e);
        end
        if (ptw_req_valid_o && ptw_prev) check_eq("ptw_b2b", ptw_prev, 0);
        ptw_prev = ptw_req_valid_o;
      end else begin
        ptw_prev = 1'b0;
      end
    end
  end

  task automatic do_req(input logic [VpnLen-1:0] vpn, input int exp_walks, input bit flush_walk);
    int w0;
    w0 = ptw_cnt;
    last_vpn = vpn;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_vpn_i   = vpn;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    check_eq("req_ready", req_ready_o, 1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    if (flush_walk) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ptw_req_valid_o) break;
      end
      @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check_eq("resp_seen", sb.size(), 0);
    check_eq("walks", ptw_cnt - w0, exp_walks);
  endtask

  task automatic flush_pulse();
    @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
  endtask

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", req_ready_o, 1);
    check_eq("rst_resp_valid", resp_valid_o, 0);
    check_eq("rst_ptw_valid", ptw_req_valid_o, 0);

    // Cold miss fills entry 0.
    do_req(27'h0012345, 1, 1'b0);
    check_eq("entry0_valid", dut.entries_q[0].valid, 1);
    check_eq("entry0_vpn", dut.entries_q[0].vpn, 27'h0012345);

    // Back-to-back hits: one response per cycle, no walks.
    w0 = ptw_cnt;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_vpn_i   = 27'h0012345;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      if (i == 3) #1 req_valid_i = 1'b0;
      @(negedge clk);
      check_eq("hit_b2b", resp_valid_o, 1);
    end
    @(negedge clk);
    check_eq("hit_sb_empty", sb.size(), 0);
    check_eq("hit_walks", ptw_cnt - w0, 0);

    // Faults pass through but are never cached.
    do_req(27'h7, 1, 1'b0);
    do_req(27'h7, 1, 1'b0);

    // Replacement: nine fills into eight entries evict entry 0.
    flush_pulse();
    for (int i = 0; i < 9; i++) do_req(27'h100 + 27'(i), 1, 1'b0);
    check_eq("evict_entry0", dut.entries_q[0].vpn, 27'h108);
    do_req(27'h101, 0, 1'b0);
    do_req(27'h100, 1, 1'b0);

    // Flush while walking: answered, not cached, old entries dropped.
    do_req(27'h200, 1, 1'b0);
    do_req(27'h108, 0, 1'b0);
    do_req(27'h400, 1, 1'b1);
    do_req(27'h200, GlobalWalks, 1'b0);
    do_req(27'h400, 1, 1'b0);
    do_req(27'h108, 1, 1'b0);

    // Reset during a walk; the late walker answer must be ignored.
    last_vpn = 27'h500;
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_vpn_i   = 27'h500;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    check_eq("rstwalk_ptw_req", ptw_req_valid_o, 1);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("rstwalk_no_resp", resp_valid_o, 0);
      check_eq("rstwalk_ready", req_ready_o, 1);
    end
    do_req(27'h200, 1, 1'b0);
    do_req(27'h0012345, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
